// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV64I subset (ld, sd, R-type, I-type, branches).
// Sequences fetch/decode/execute/memory/writeback and drives datapath enables and ALUop.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic       PCwrite,
  output logic       PCwriteCond,
  output logic       PCsource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRwrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       done;
    logic       ill;
  } ctrl_t;

  state_t cur_state, nxt_state;
  ctrl_t  ctrl, ctrl_out;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= state_t'(RESET_STATE);
    else        cur_state <= nxt_state;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    ctrl      = '0;
    nxt_state = S_FETCH;
    unique case (cur_state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.src_b    = SRCB_4;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          nxt_state     = S_DECODE;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target PC + imm into ALUOut.
        ctrl.src_b = SRCB_IMM;
        case (opcode)
          OP_LD, OP_SD: nxt_state = S_MEMADDR;
          OP_RTYPE:     nxt_state = S_EXEC_R;
          OP_ITYPE:     nxt_state = S_EXEC_I;
          OP_BRANCH:    nxt_state = S_BRANCH;
          default: begin
            ctrl.ill  = 1'b1;
            ctrl.done = 1'b1;
            nxt_state = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = SRCB_IMM;
        nxt_state  = (opcode == OP_SD) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        nxt_state     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.done       = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.done      = mem_ready;
        nxt_state      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC_R: begin
        ctrl.src_a  = 1'b1;
        ctrl.src_b  = SRCB_RS2;
        ctrl.alu_op = ALU_R;
        nxt_state   = S_ALUWB;
      end
      S_EXEC_I: begin
        ctrl.src_a  = 1'b1;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALU_I;
        nxt_state   = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.src_a         = 1'b1;
        ctrl.src_b         = SRCB_RS2;
        ctrl.alu_op        = ALU_BR;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.done          = 1'b1;
      end
      default: begin
        // Unused encodings recover to FETCH with every output quiet.
        ctrl      = '0;
        nxt_state = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low combinationally during reset so an aborted memory
  // request drops in the same cycle reset is asserted.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign ALUop       = ctrl_out.alu_op;
  assign ALUsrcA     = ctrl_out.src_a;
  assign ALUsrcB     = ctrl_out.src_b;
  assign PCwrite     = ctrl_out.pc_write;
  assign PCwriteCond = ctrl_out.pc_write_cond;
  assign PCsource    = ctrl_out.pc_source;
  assign IorD        = ctrl_out.iord;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRwrite     = ctrl_out.ir_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign instr_done  = ctrl_out.done;
  assign illegal     = ctrl_out.ill;
  assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one task per scenario, expected control
// vectors written out by hand per cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b1;
  logic [1:0] ALUop;
  logic       ALUsrcA;
  logic [1:0] ALUsrcB;
  logic       PCwrite, PCwriteCond, PCsource, IorD, MemRead, MemWrite;
  logic       IRwrite, RegWrite, MemtoReg, instr_done, illegal;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  logic [19:0] obs;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ALUop(ALUop), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .PCwrite(PCwrite),
    .PCwriteCond(PCwriteCond), .PCsource(PCsource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRwrite(IRwrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Packs hand-written expected fields in the same order as snap().
  function automatic logic [19:0] mk(input logic [1:0] aluop, input logic sa,
      input logic [1:0] sb, input logic pcw, input logic pcwc, input logic pcs,
      input logic iord, input logic mr, input logic mw, input logic irw,
      input logic rw, input logic m2r, input logic done, input logic ill,
      input logic [3:0] st);
    return {aluop, sa, sb, pcw, pcwc, pcs, iord, mr, mw, irw, rw, m2r, done, ill, st};
  endfunction

  function automatic logic [19:0] snap();
    return {ALUop, ALUsrcA, ALUsrcB, PCwrite, PCwriteCond, PCsource, IorD, MemRead,
            MemWrite, IRwrite, RegWrite, MemtoReg, instr_done, illegal, state};
  endfunction

  // One clock cycle: drive on the falling edge, observe 1 ns later.
  task automatic cyc(input logic r, input logic [6:0] op, input logic rdy);
    @(negedge clk);
    rst_n = r; opcode = op; mem_ready = rdy;
    #1;
    obs = snap();
  endtask

  task automatic test_reset();
    logic [19:0] exp [7];
    logic        rs  [7];
    exp = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0),
            mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0),
            mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0),  // FETCH, ready
            mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1),  // DECODE
            mk(2,1,0,0,0,0,0,0,0,0,0,0,0,0,6),  // EXEC_R
            mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0,8)}; // ALUWB
    rs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cyc(rs[i], OP_R, 1'b1);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_ld();
    logic [19:0] exp [5];
    exp = '{mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0), mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1),
            mk(0,1,2,0,0,0,0,0,0,0,0,0,0,0,2), mk(0,0,0,0,0,0,1,1,0,0,0,0,0,0,3),
            mk(0,0,0,0,0,0,0,0,0,0,1,1,1,0,4)};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, OP_LD, 1'b1);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL ld cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_sd_wait();
    logic [19:0] exp [6];
    logic        rdy [6];
    exp = '{mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0), mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1),
            mk(0,1,2,0,0,0,0,0,0,0,0,0,0,0,2), mk(0,0,0,0,0,0,1,0,1,0,0,0,0,0,5),
            mk(0,0,0,0,0,0,1,0,1,0,0,0,0,0,5), mk(0,0,0,0,0,0,1,0,1,0,0,0,1,0,5)};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, OP_SD, rdy[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL sd_wait cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp [8];
    exp = '{mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0), mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1),
            mk(2,1,0,0,0,0,0,0,0,0,0,0,0,0,6), mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0,8),
            mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0), mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1),
            mk(3,1,2,0,0,0,0,0,0,0,0,0,0,0,7), mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0,8)};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (i < 4) ? OP_R : OP_I, 1'b1);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  // One FETCH wait cycle first; mem_ready low in DECODE must be ignored.
  task automatic test_branch();
    logic [19:0] exp [4];
    logic        rdy [4];
    exp = '{mk(0,0,1,0,0,0,0,1,0,0,0,0,0,0,0), mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0),
            mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1), mk(1,1,0,0,1,1,0,0,0,0,0,0,1,0,9)};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, OP_BR, rdy[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL branch cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [19:0] exp [2];
    exp = '{mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0), mk(0,0,2,0,0,0,0,0,0,0,0,0,1,1,1)};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, OP_BAD, 1'b1);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  // Starts at FETCH right after the illegal instruction; reset lands mid-MEMRD.
  task automatic test_abort();
    logic [19:0] exp [4];
    logic        rdy [4];
    logic [19:0] zero_v, fetch_v;
    exp = '{mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0), mk(0,0,2,0,0,0,0,0,0,0,0,0,0,0,1),
            mk(0,1,2,0,0,0,0,0,0,0,0,0,0,0,2), mk(0,0,0,0,0,0,1,1,0,0,0,0,0,0,3)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    zero_v  = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    fetch_v = mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, OP_LD, rdy[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
    rst_n = 1'b0;
    #1;
    obs = snap();
    checks++;
    if (obs !== zero_v) begin
      errors++;
      $display("FAIL abort_same_cycle: got %h expected %h", obs, zero_v);
    end
    cyc(1'b0, OP_LD, 1'b1);
    checks++;
    if (obs !== zero_v) begin
      errors++;
      $display("FAIL abort_held: got %h expected %h", obs, zero_v);
    end
    cyc(1'b1, OP_LD, 1'b1);
    checks++;
    if (obs !== fetch_v) begin
      errors++;
      $display("FAIL abort_release: got %h expected %h", obs, fetch_v);
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_sd_wait();
    test_back_to_back();
    test_branch();
    test_illegal();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the RV64I subset (ld, sd, R-type ALU, I-type ALU, conditional branches). Sits directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables, and drives the 2-bit `ALUop` that the ALU control decoder combines with funct7/funct3. Memory accesses use a ready handshake, so instruction and data memory may insert wait states.

## Interface
Parameters:
- `RESET_STATE`, default 4'd0 (FETCH): state loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction[6:0] from the instruction register; sampled in DECODE.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `ALUop`  out  2  00 = add (ld/sd/PC/target), 01 = branch compare, 10 = R-type, 11 = I-type.
- `ALUsrcA`  out  1  0 = PC, 1 = rs1.
- `ALUsrcB`  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- `PCwrite`  out  1  unconditional PC load from ALU result.
- `PCwriteCond`  out  1  PC load from ALUOut when the datapath branch condition holds.
- `PCsource`  out  1  0 = ALU result, 1 = ALUOut register.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRwrite`  out  1  load instruction register.
- `RegWrite`  out  1  register file write.
- `MemtoReg`  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal`  out  1  one-cycle pulse: unsupported opcode seen in DECODE.
- `state`  out  4  current state, for debug.

## Operation
State encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9. Codes 10–15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.

Outputs are a function of state (plus `mem_ready` where noted). Any output not listed for a state is 0, and `ALUop` defaults to 00.

- FETCH: `MemRead`=1, `IorD`=0, `ALUsrcA`=0, `ALUsrcB`=01.
  - When `mem_ready`=1, also assert `IRwrite`=1 and `PCwrite`=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: `ALUsrcA`=0, `ALUsrcB`=10. This computes the branch target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEMADDR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1100011 → BRANCH.
  - Any other opcode → FETCH, with `illegal`=1 and `instr_done`=1.
- MEMADDR: `ALUsrcA`=1, `ALUsrcB`=10. The opcode held in IR selects MEMRD (ld) or MEMWR (sd).
- MEMRD: `MemRead`=1, `IorD`=1. Hold until `mem_ready`=1, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `instr_done`=1 → FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Hold until `mem_ready`=1; in that cycle assert `instr_done`=1, then go to FETCH.
- EXEC_R: `ALUsrcA`=1, `ALUsrcB`=00, `ALUop`=10 → ALUWB.
- EXEC_I: `ALUsrcA`=1, `ALUsrcB`=10, `ALUop`=11 → ALUWB.
- ALUWB: `RegWrite`=1, `MemtoReg`=0, `instr_done`=1 → FETCH.
- BRANCH: `ALUsrcA`=1, `ALUsrcB`=00, `ALUop`=01, `PCwriteCond`=1, `PCsource`=1, `instr_done`=1 → FETCH.

Request and handshake rules:
- `MemRead` and `MemWrite` are never both 1.
- A memory request, once raised, is held with stable `IorD` until the cycle `mem_ready`=1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Reset: while `rst_n`=0, `state` = RESET_STATE and every output is forced to 0 combinationally.
  - FETCH outputs appear in the first cycle after deassertion.
  - Reset asserted mid-instruction (e.g. during MEMWR) drops `MemWrite` immediately. No `instr_done` is produced for the aborted instruction.
- Latency with `mem_ready` tied to 1: ld 5 cycles, sd 4, R-type 4, I-type 4, branch 3, illegal 2.
- Each wait cycle (`mem_ready`=0) in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `instr_done` is exactly one cycle per completed or illegal instruction. Back-to-back instructions have no idle cycle: FETCH follows the done cycle directly.
- `opcode` needs to be stable only from DECODE until the instruction completes; IR is written only in FETCH.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → all outputs 0 and `state`=0. In the first cycle after release, `MemRead`=1, `IRwrite`=1, `PCwrite`=1.
- ld, zero wait: opcode 0000011 → states 0,1,2,3,4.
  - `ALUop`=00 throughout.
  - `MemRead`=1 with `IorD`=1 in state 3.
  - `RegWrite`=1 and `MemtoReg`=1 in state 4, with `instr_done`=1 in the fifth cycle.
- sd with `mem_ready` low for 2 cycles in MEMWR → `MemWrite` held 3 cycles with `IorD`=1, then `instr_done` coincides with `mem_ready`=1. Total 6 cycles.
- R-type then I-type back to back: opcodes 0110011, 0010011 → `ALUop`=10 in EXEC_R and 11 in EXEC_I. `instr_done` pulses at cycles 4 and 8, with no idle cycle between.
- Branch: opcode 1100011 → `ALUop`=01, `PCwriteCond`=1, `PCsource`=1 in the third cycle; `PCwrite`=0 there.
- Illegal and abort:
  - Opcode 1111111 → `illegal`=1 and `instr_done`=1 in DECODE; next state FETCH; `RegWrite` and `MemWrite` never asserted.
  - Separately, drop `rst_n` while in MEMRD → all outputs 0 in the same cycle, and `state`=0.
